// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the combinational imem and registers each
// fetched word with its PC into a single-entry valid/ready stage towards decode.
package riscv_pkg;
    localparam int XLEN            = 32;
    localparam int WORD_ADDR_WIDTH = 8;
    localparam int IMEM_SIZE       = 256;  // words
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
endpackage

module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [WORD_ADDR_WIDTH-1:0] imem_addr,
    input  logic [XLEN-1:0]            imem_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic                       out_fault,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       halt_req,
    output logic                       halted
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    localparam logic [XLEN-3:0] IMEM_WORDS = (XLEN-2)'(IMEM_SIZE);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic            out_valid_q;
    logic            out_fault_q;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] out_instr_q;

    logic fire;
    logic bad;

    // A halt request takes effect immediately, so it also suppresses this cycle's fetch.
    assign fire = (state_q == ST_RUN) && (!out_valid_q || out_ready)
                  && !redirect_valid && !halt_req;

    // Range check uses the full PC so that high bits dropped by imem_addr still fault.
    assign bad = (pc_q[1:0] != 2'b00) || (pc_q[XLEN-1:2] >= IMEM_WORDS);

    // NOTE: all state lives in this one clocked block and uses non-blocking assignments,
    // so every decision below sees the values from the start of the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else if (redirect_valid) begin
            // A handshake in this cycle retires the old output; it is simply dropped.
            state_q     <= ST_RUN;
            pc_q        <= redirect_pc;
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
        end else begin
            if (fire) begin
                out_valid_q <= 1'b1;
                out_pc_q    <= pc_q;
                if (bad) begin
                    out_instr_q <= NOP_INSTR;
                    out_fault_q <= 1'b1;
                    state_q     <= ST_FAULT;
                end else begin
                    out_instr_q <= imem_instr;
                    out_fault_q <= 1'b0;
                    pc_q        <= pc_q + XLEN'(4);
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (state_q == ST_RUN && halt_req) begin
                state_q <= ST_HALT;
            end
        end
    end

    assign imem_addr = pc_q[WORD_ADDR_WIDTH+1:2];
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_fault = out_fault_q;
    assign halted    = (state_q != ST_RUN);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of per-cycle inputs and expected outputs,
// followed by a hand-written halt/resume sequence.
module tb_fetch_ctrl;
    import riscv_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [WORD_ADDR_WIDTH-1:0] imem_addr;
    logic [XLEN-1:0]            imem_instr;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_pc;
    logic [XLEN-1:0]            out_instr;
    logic                       out_fault;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_pc;
    logic                       halt_req;
    logic                       halted;

    logic [XLEN-1:0] imem [IMEM_SIZE];

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr];

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        halt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
        logic        e_halted;
        logic [7:0]  e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    task automatic vec(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic ev, input logic [31:0] epc,
                       input logic [31:0] ei, input logic ef, input logic eh, input logic [7:0] ea);
        vec_t v;
        v = '{r, rdy, rv, rpc, h, ev, epc, ei, ef, eh, ea};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input logic h);
        rst            = r;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < IMEM_SIZE; i++) imem[i] = word(i);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        //   rst rdy rv  rpc           halt  valid pc            instr       flt  hlt  addr
        // reset, then streaming A,B,C,D
        vec(1, 0, 0, 32'h0,        0,    0, 32'h0,        32'h0,      0,   0,   8'd0);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h0,        word(0),    0,   0,   8'd1);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h4,        word(1),    0,   0,   8'd2);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h8,        word(2),    0,   0,   8'd3);
        vec(0, 1, 0, 32'h0,        0,    1, 32'hC,        word(3),    0,   0,   8'd4);
        // backpressure on B @ 4 for three cycles
        vec(1, 1, 0, 32'h0,        0,    0, 32'h0,        32'h0,      0,   0,   8'd0);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h0,        word(0),    0,   0,   8'd1);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h4,        word(1),    0,   0,   8'd2);
        vec(0, 0, 0, 32'h0,        0,    1, 32'h4,        word(1),    0,   0,   8'd2);
        vec(0, 0, 0, 32'h0,        0,    1, 32'h4,        word(1),    0,   0,   8'd2);
        vec(0, 0, 0, 32'h0,        0,    1, 32'h4,        word(1),    0,   0,   8'd2);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h8,        word(2),    0,   0,   8'd3);
        // redirect during a stall
        vec(0, 0, 1, 32'h40,       0,    0, 32'h8,        word(2),    0,   0,   8'd16);
        vec(0, 0, 0, 32'h0,        0,    1, 32'h40,       word(16),   0,   0,   8'd17);
        // halt with a handshake in the same cycle, then resume via redirect
        vec(0, 1, 0, 32'h0,        1,    0, 32'h40,       word(16),   0,   1,   8'd17);
        vec(0, 1, 0, 32'h0,        0,    0, 32'h40,       word(16),   0,   1,   8'd17);
        vec(0, 1, 1, 32'h8,        0,    0, 32'h40,       word(16),   0,   0,   8'd2);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h8,        word(2),    0,   0,   8'd3);
        // misaligned fault, held under stall, then drained
        vec(0, 1, 1, 32'h2,        0,    0, 32'h8,        word(2),    0,   0,   8'd0);
        vec(0, 0, 0, 32'h0,        0,    1, 32'h2,        NOP_INSTR,  1,   1,   8'd0);
        vec(0, 0, 0, 32'h0,        0,    1, 32'h2,        NOP_INSTR,  1,   1,   8'd0);
        vec(0, 1, 0, 32'h0,        0,    0, 32'h2,        NOP_INSTR,  1,   1,   8'd0);
        // out-of-range fault at IMEM_SIZE*4 (imem_addr wraps to 0)
        vec(0, 1, 1, 32'h400,      0,    0, 32'h2,        NOP_INSTR,  0,   0,   8'd0);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h400,      NOP_INSTR,  1,   1,   8'd0);
        vec(0, 1, 0, 32'h0,        0,    0, 32'h400,      NOP_INSTR,  1,   1,   8'd0);
        // redirect and halt together: redirect wins
        vec(0, 1, 1, 32'h10,       1,    0, 32'h400,      NOP_INSTR,  0,   0,   8'd4);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h10,       word(4),    0,   0,   8'd5);
        vec(0, 0, 0, 32'h0,        0,    1, 32'h10,       word(4),    0,   0,   8'd5);
        // reset during a stall with a redirect pending
        vec(1, 0, 1, 32'h80,       1,    0, 32'h0,        32'h0,      0,   0,   8'd0);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h0,        word(0),    0,   0,   8'd1);
        // last in-range word, then the first out-of-range one
        vec(0, 1, 1, 32'h3FC,      0,    0, 32'h0,        word(0),    0,   0,   8'd255);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h3FC,      word(255),  0,   0,   8'd0);
        vec(0, 1, 0, 32'h0,        0,    1, 32'h400,      NOP_INSTR,  1,   1,   8'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc, vecs[i].halt);
            step();
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d out_pc",    i), out_pc,         vecs[i].e_pc);
            check($sformatf("v%0d out_instr", i), out_instr,      vecs[i].e_instr);
            check($sformatf("v%0d out_fault", i), 32'(out_fault), 32'(vecs[i].e_fault));
            check($sformatf("v%0d halted",    i), 32'(halted),    32'(vecs[i].e_halted));
            check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
        end

        // Halt right after a redirect: nothing of the new stream may be fetched.
        drive(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        check("seq halt_now", 32'(halted), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("seq halt_idle%0d", c), 32'(out_valid), 32'd0);
        end
        // halt_req while already halted changes nothing
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        check("seq halt_again", 32'(halted), 32'd1);
        check("seq halt_again_addr", 32'(imem_addr), 32'd8);

        // Resume and wait (bounded) for the first instruction of the new stream.
        drive(1'b0, 1'b1, 1'b1, 32'h24, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        begin
            int waited = 0;
            while (!out_valid && waited < 5) begin
                step();
                waited++;
            end
            check("seq resume_timeout", 32'(out_valid), 32'd1);
            check("seq resume_latency", 32'(waited), 32'd1);
            check("seq resume_pc", out_pc, 32'h24);
            check("seq resume_instr", out_instr, word(9));
        end
        step();
        check("seq next_pc", out_pc, 32'h28);
        check("seq next_instr", out_instr, word(10));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
